// File: rtl/ram_access_ctrl.sv
// Command front-end for an 8x8 RAM with a posedge-registered read port.
// Serialises single-word writes and reads, and can sweep-clear every word.
module ram_access_ctrl #(
  parameter logic [7:0] CLR_VALUE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_we,
  input  logic [2:0] cmd_addr,
  input  logic [7:0] cmd_data,
  input  logic       clr_start,
  output logic       busy,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       ram_we,
  output logic [2:0] ram_inaddr,
  output logic [2:0] ram_outaddr,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR     = 3'd1,
    RD     = 3'd2,
    RD_CAP = 3'd3,
    CLR    = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] clr_cnt;
  logic [2:0] clr_cnt_nxt;
  logic       accept;

  logic       ram_we_nxt;
  logic [2:0] ram_inaddr_nxt;
  logic [2:0] ram_outaddr_nxt;
  logic [7:0] ram_din_nxt;
  logic       rsp_valid_nxt;
  logic [7:0] rsp_data_nxt;

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_we/addr/data are sampled only at that edge.
  // A pending clear request masks cmd_ready so the clear always wins.
  assign cmd_ready = (state == IDLE) && !clr_start;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE);

  // State register plus the registered RAM-side and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      clr_cnt     <= 3'd0;
      ram_we      <= 1'b0;
      ram_inaddr  <= 3'd0;
      ram_outaddr <= 3'd0;
      ram_din     <= 8'h00;
      rsp_valid   <= 1'b0;
      rsp_data    <= 8'h00;
    end else begin
      state       <= state_nxt;
      clr_cnt     <= clr_cnt_nxt;
      ram_we      <= ram_we_nxt;
      ram_inaddr  <= ram_inaddr_nxt;
      ram_outaddr <= ram_outaddr_nxt;
      ram_din     <= ram_din_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_data    <= rsp_data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nxt = CLR;
        end else if (accept) begin
          state_nxt = cmd_we ? WR : RD;
        end
      end
      WR:     state_nxt = IDLE;
      RD:     state_nxt = RD_CAP;
      RD_CAP: state_nxt = IDLE;
      CLR: begin
        if (clr_cnt == 3'd7) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs; addresses and write data hold
  // unless a transfer or sweep step loads them.
  always_comb begin
    ram_we_nxt      = 1'b0;
    ram_inaddr_nxt  = ram_inaddr;
    ram_outaddr_nxt = ram_outaddr;
    ram_din_nxt     = ram_din;
    rsp_valid_nxt   = 1'b0;
    rsp_data_nxt    = rsp_data;
    clr_cnt_nxt     = clr_cnt;
    case (state)
      IDLE: begin
        if (clr_start) begin
          ram_we_nxt     = 1'b1;
          ram_inaddr_nxt = 3'd0;
          ram_din_nxt    = CLR_VALUE;
          clr_cnt_nxt    = 3'd0;
        end else if (accept) begin
          if (cmd_we) begin
            ram_we_nxt     = 1'b1;
            ram_inaddr_nxt = cmd_addr;
            ram_din_nxt    = cmd_data;
          end else begin
            ram_outaddr_nxt = cmd_addr;
          end
        end
      end
      RD_CAP: begin
        // ram_dout now carries the word addressed during RD.
        rsp_valid_nxt = 1'b1;
        rsp_data_nxt  = ram_dout;
      end
      CLR: begin
        clr_cnt_nxt = clr_cnt + 3'd1;
        if (clr_cnt != 3'd7) begin
          ram_we_nxt     = 1'b1;
          ram_inaddr_nxt = clr_cnt + 3'd1;
          ram_din_nxt    = CLR_VALUE;
        end
      end
      default: begin
        ram_we_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: external RAM model, behavioural memory image and
// an expected-read queue; one task per scenario.
module tb_ram_access_ctrl;

  localparam logic [7:0] CLR_VAL = 8'h00;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_we;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       clr_start;
  logic       busy;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       ram_we;
  logic [2:0] ram_inaddr;
  logic [2:0] ram_outaddr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;

  logic [7:0] ram [8];
  logic [7:0] ref_mem [8];
  logic [7:0] exp_q [$];

  ram_access_ctrl #(.CLR_VALUE(CLR_VAL)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .clr_start(clr_start),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_we(ram_we), .ram_inaddr(ram_inaddr), .ram_outaddr(ram_outaddr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Clock / reset-independent environment
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_we) ram[ram_inaddr] <= ram_din;
    ram_dout <= ram[ram_outaddr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic we, input logic [2:0] a, input logic [7:0] d);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_data = d;
    while (!cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      last_acc = cyc;
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    issue(1'b1, a, d);
    ref_mem[a] = d;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_read(input logic [2:0] a, output logic [7:0] d, output int lat);
    issue(1'b0, a, 8'h00);
    lat = 0;
    d = 8'h00;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        d = rsp_data;
        break;
      end
    end
  endtask

  task automatic clear_pulse();
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 3'd0; cmd_data = 8'h00; clr_start = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, ram_we, rsp_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: busy/we/rsp_valid=%b, required 000", {busy, ram_we, rsp_valid});
    end
    checks++;
    if ({ram_inaddr, ram_outaddr, ram_din, rsp_data} !== 22'd0) begin
      errors++; $display("FAIL reset_regs: inaddr=%0d outaddr=%0d din=%h rsp=%h, required 0", ram_inaddr, ram_outaddr, ram_din, rsp_data);
    end
    clr_start = 1'b1; #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_clr: cmd_ready=%b, required 0", cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_priority: busy=%b, required 0", busy);
    end
    clr_start = 1'b0; #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: cmd_ready=%b, required 1", cmd_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    logic [7:0] d;
    int lat;
    issue(1'b1, 3'd3, 8'hA5);
    ref_mem[3] = 8'hA5;
    @(negedge clk);
    checks++;
    if ({busy, ram_we, ram_inaddr, ram_din} !== {1'b1, 1'b1, 3'd3, 8'hA5}) begin
      errors++; $display("FAIL wr_cycle: busy=%b we=%b inaddr=%0d din=%h, required 1 1 3 a5", busy, ram_we, ram_inaddr, ram_din);
    end
    @(negedge clk);
    checks++;
    if ({busy, ram_we, cmd_ready, ram_inaddr, ram_din} !== {1'b0, 1'b0, 1'b1, 3'd3, 8'hA5}) begin
      errors++; $display("FAIL wr_done: busy=%b we=%b ready=%b inaddr=%0d din=%h, required 0 0 1 3 a5", busy, ram_we, cmd_ready, ram_inaddr, ram_din);
    end
    do_read(3'd3, d, lat);
    checks++;
    if (lat !== 3 || d !== 8'hA5) begin
      errors++; $display("FAIL rd_a5: latency=%0d data=%h, required 3 a5", lat, d);
    end
    checks++;
    if (ram_outaddr !== 3'd3 || busy !== 1'b0) begin
      errors++; $display("FAIL rd_outaddr: outaddr=%0d busy=%b, required 3 0", ram_outaddr, busy);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'hA5) begin
      errors++; $display("FAIL rd_hold: rsp_valid=%b rsp_data=%h, required 0 a5", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    int lat, a1, a2;
    do_write(3'd5, 8'h3C);
    a1 = last_acc;
    do_read(3'd5, d, lat);
    a2 = last_acc;
    checks++;
    if (d !== 8'h3C || lat !== 3) begin
      errors++; $display("FAIL b2b_data: data=%h latency=%0d, required 3c 3", d, lat);
    end
    checks++;
    if (a2 - a1 !== 2) begin
      errors++; $display("FAIL b2b_wr_gap: gap=%0d, required 2", a2 - a1);
    end
    do_read(3'd3, d, lat);
    checks++;
    if (last_acc - a2 !== 3 || d !== ref_mem[3]) begin
      errors++; $display("FAIL b2b_rd_gap: gap=%0d data=%h, required 3 %h", last_acc - a2, d, ref_mem[3]);
    end
  endtask

  task automatic test_clear();
    logic [7:0] d;
    int lat;
    clear_pulse();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({busy, ram_we, cmd_ready, ram_inaddr, ram_din} !== {1'b1, 1'b1, 1'b0, 3'(k), CLR_VAL}) begin
        errors++; $display("FAIL clr_step%0d: busy=%b we=%b ready=%b inaddr=%0d din=%h, required 1 1 0 %0d %h",
                           k, busy, ram_we, cmd_ready, ram_inaddr, ram_din, k, CLR_VAL);
      end
      if (k == 4) clr_start = 1'b1;
      if (k == 5) clr_start = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ram_we !== 1'b0) begin
      errors++; $display("FAIL clr_end: busy=%b we=%b, required 0 0", busy, ram_we);
    end
    for (int i = 0; i < 8; i++) ref_mem[i] = CLR_VAL;
    for (int i = 0; i < 8; i++) begin
      do_read(3'(i), d, lat);
      checks++;
      if (d !== ref_mem[i] || lat !== 3) begin
        errors++; $display("FAIL clr_read%0d: data=%h latency=%0d, required %h 3", i, d, lat, ref_mem[i]);
      end
    end
  endtask

  task automatic test_clr_priority();
    logic [7:0] d;
    int lat;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 3'd2; cmd_data = 8'hFF; clr_start = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL prio_ready: cmd_ready=%b, required 0", cmd_ready);
    end
    @(posedge clk); #1;
    clr_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if ({ram_we, cmd_ready, ram_inaddr, ram_din} !== {1'b1, 1'b0, 3'(k), CLR_VAL}) begin
        errors++; $display("FAIL prio_clr%0d: we=%b ready=%b inaddr=%0d din=%h, required 1 0 %0d %h",
                           k, ram_we, cmd_ready, ram_inaddr, ram_din, k, CLR_VAL);
      end
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL prio_idle: cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) ref_mem[i] = CLR_VAL;
    ref_mem[2] = 8'hFF;
    @(negedge clk);
    checks++;
    if ({ram_we, ram_inaddr, ram_din} !== {1'b1, 3'd2, 8'hFF}) begin
      errors++; $display("FAIL prio_write: we=%b inaddr=%0d din=%h, required 1 2 ff", ram_we, ram_inaddr, ram_din);
    end
    do_read(3'd2, d, lat);
    checks++;
    if (d !== ref_mem[2]) begin
      errors++; $display("FAIL prio_read2: data=%h, required %h", d, ref_mem[2]);
    end
    do_read(3'd6, d, lat);
    checks++;
    if (d !== ref_mem[6]) begin
      errors++; $display("FAIL prio_read6: data=%h, required %h", d, ref_mem[6]);
    end
  endtask

  task automatic test_rst_in_clr();
    logic [7:0] d;
    int lat;
    for (int i = 0; i < 8; i++) do_write(3'(i), 8'($urandom_range(1, 255)));
    clear_pulse();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 3) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ram_we, busy, ram_inaddr, ram_din} !== {1'b0, 1'b0, 3'd0, 8'h00}) begin
      errors++; $display("FAIL rstclr_regs: we=%b busy=%b inaddr=%0d din=%h, required 0 0 0 00", ram_we, busy, ram_inaddr, ram_din);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (ram_we !== 1'b0) begin
        errors++; $display("FAIL rstclr_we%0d: we=%b, required 0", k, ram_we);
      end
    end
    for (int i = 0; i < 4; i++) ref_mem[i] = CLR_VAL;
    for (int i = 0; i < 8; i++) begin
      do_read(3'(i), d, lat);
      checks++;
      if (d !== ref_mem[i]) begin
        errors++; $display("FAIL rstclr_read%0d: data=%h, required %h", i, d, ref_mem[i]);
      end
    end
  endtask

  task automatic test_rst_in_rdcap();
    logic [7:0] d;
    int lat;
    do_write(3'd1, 8'h5A);
    do_read(3'd1, d, lat);
    checks++;
    if (d !== 8'h5A) begin
      errors++; $display("FAIL rdcap_pre: data=%h, required 5a", d);
    end
    issue(1'b0, 3'd1, 8'h00);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rdcap_busy: busy=%b, required 1", busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_data, cmd_ready, busy} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
      errors++; $display("FAIL rdcap_rst: rsp_valid=%b rsp_data=%h ready=%b busy=%b, required 0 00 1 0", rsp_valid, rsp_data, cmd_ready, busy);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rdcap_late: rsp_valid=%b, required 0", rsp_valid);
    end
  endtask

  task automatic test_random();
    logic [7:0] d, e;
    logic [2:0] a;
    int lat, op, nbusy;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 9);
      a = 3'($urandom_range(0, 7));
      if (op == 0) begin
        clear_pulse();
        nbusy = 0;
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          if (!busy) break;
          nbusy++;
        end
        for (int j = 0; j < 8; j++) ref_mem[j] = CLR_VAL;
        checks++;
        if (nbusy !== 8) begin
          errors++; $display("FAIL rand_clr_len: busy cycles=%0d, required 8", nbusy);
        end
      end else if (op <= 4) begin
        do_write(a, 8'($urandom));
      end else begin
        exp_q.push_back(ref_mem[a]);
        do_read(a, d, lat);
        e = exp_q.pop_front();
        checks++;
        if (d !== e || lat !== 3) begin
          errors++; $display("FAIL rand_read a=%0d: data=%h latency=%0d, required %h 3", a, d, lat, e);
        end
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_clear();
    test_clr_priority();
    test_rst_in_clr();
    test_rst_in_rdcap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
